// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned BURST_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Saturating increment of the consecutive-data-grant counter.
  function automatic logic [BURST_W-1:0] burst_sat_inc(
    input logic [BURST_W-1:0] cnt,
    input logic [BURST_W-1:0] limit
  );
    return (cnt == limit) ? cnt : cnt + BURST_W'(1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and backing-memory handshake signals.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_ack_o;
  logic [DATA_W-1:0] i_rdata_o;
  logic              if_stall_o;

  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_ack_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              mem_stall_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              err_o;

  // Arbiter side.
  modport slave (
    input  i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
    input  mem_ack_i, mem_rdata_i,
    output i_ack_o, i_rdata_o, if_stall_o, d_ack_o, d_rdata_o, mem_stall_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );

  // Pipeline / memory-model side.
  modport master (
    output i_req_i, i_addr_i, d_req_i, d_we_i, d_addr_i, d_wdata_i,
    output mem_ack_i, mem_rdata_i,
    input  i_ack_o, i_rdata_o, if_stall_o, d_ack_o, d_rdata_o, mem_stall_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, err_o
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Data-first priority pick, yielding to a waiting fetch once the data burst limit is hit.
module mem_port_arbiter_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic               i_i_req,
  input  logic               i_d_req,
  input  logic [BURST_W-1:0] i_burst_cnt,
  output logic               o_gnt_valid_c,
  output port_e              o_gnt_port_c
);

  localparam logic [BURST_W-1:0] LIMIT = BURST_W'(MAX_D_BURST);

  logic w_d_win;

  assign w_d_win       = i_d_req & ~(i_i_req & (i_burst_cnt == LIMIT));
  assign o_gnt_valid_c = w_d_win | i_i_req;
  assign o_gnt_port_c  = w_d_win ? PORT_D : PORT_I;

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF and MEM-stage accesses onto one single-port memory with
// registered handshakes, one-cycle acks and a bounded data burst.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned MAX_D_BURST = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  mem_port_arbiter_if.slave        bus
);

  localparam logic [BURST_W-1:0] LIMIT = BURST_W'(MAX_D_BURST);

  state_e             r_state;
  logic [BURST_W-1:0] r_burst_cnt;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_i_ack;
  logic               r_d_ack;
  logic [DATA_W-1:0]  r_i_rdata;
  logic [DATA_W-1:0]  r_d_rdata;
  logic               r_err;

  logic               w_gnt_valid;
  port_e              w_gnt_port;

  mem_port_arbiter_pick #(
    .MAX_D_BURST (MAX_D_BURST)
  ) u_pick (
    .i_i_req       (bus.i_req_i),
    .i_d_req       (bus.d_req_i),
    .i_burst_cnt   (r_burst_cnt),
    .o_gnt_valid_c (w_gnt_valid),
    .o_gnt_port_c  (w_gnt_port)
  );

  // Request latch, handshake FSM, burst counter and error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.mem_ack_i) begin
            r_err <= 1'b1;
          end
          if (w_gnt_valid) begin
            r_mem_req <= 1'b1;
            if (w_gnt_port == PORT_D) begin
              r_state     <= SERVE_D;
              r_mem_we    <= bus.d_we_i;
              r_mem_addr  <= bus.d_addr_i;
              r_mem_wdata <= bus.d_wdata_i;
              r_burst_cnt <= bus.i_req_i ? burst_sat_inc(r_burst_cnt, LIMIT) : '0;
            end else begin
              r_state     <= SERVE_I;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= bus.i_addr_i;
              r_mem_wdata <= '0;
              r_burst_cnt <= '0;
            end
          end
        end
        SERVE_D, SERVE_I: begin
          if (bus.mem_ack_i) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
            if (r_state == SERVE_D) begin
              r_d_ack   <= 1'b1;
              r_d_rdata <= bus.mem_rdata_i;
            end else begin
              r_i_ack   <= 1'b1;
              r_i_rdata <= bus.mem_rdata_i;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.i_ack_o     = r_i_ack;
  assign bus.d_ack_o     = r_d_ack;
  assign bus.i_rdata_o   = r_i_rdata;
  assign bus.d_rdata_o   = r_d_rdata;
  assign bus.err_o       = r_err;

  // Stalls are combinational so the pipeline releases in the ack cycle itself.
  assign bus.if_stall_o  = bus.i_req_i & ~r_i_ack;
  assign bus.mem_stall_o = bus.d_req_i & ~r_d_ack;

endmodule
